// File: rtl/instr_fetch_queue_if.sv
// Fetch/decode-facing bundle of the instruction fetch queue: push side from
// fetch, pop side with pre-split head fields toward decode.
interface instr_fetch_queue_if #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
);
    logic                     flush_in;
    logic                     push_valid_in;
    logic                     push_ready_out;
    logic [31:0]              instr_in;
    logic [PC_WIDTH-1:0]      pc_in;
    logic                     pop_ready_in;
    logic                     pop_valid_out;
    logic [PC_WIDTH-1:0]      pc_out;
    logic [6:0]               opcode_out;
    logic [2:0]               funct3_out;
    logic [6:0]               funct7_out;
    logic [4:0]               rs1_addr_out;
    logic [4:0]               rs2_addr_out;
    logic [4:0]               rd_addr_out;
    logic [11:0]              csr_addr_out;
    logic [24:0]              instr_31_7_out;
    logic [$clog2(DEPTH):0]   count_out;

    // The queue itself
    modport slave (
        input  flush_in, push_valid_in, instr_in, pc_in, pop_ready_in,
        output push_ready_out, pop_valid_out, pc_out, opcode_out, funct3_out,
               funct7_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
               csr_addr_out, instr_31_7_out, count_out
    );

    // Fetch/decode side driving the queue
    modport master (
        output flush_in, push_valid_in, instr_in, pc_in, pop_ready_in,
        input  push_ready_out, pop_valid_out, pc_out, opcode_out, funct3_out,
               funct7_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
               csr_addr_out, instr_31_7_out, count_out
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction/PC buffer between fetch and decode. The head entry is shown
// pre-split into fields; a NOP is substituted whenever the head is not valid.
module instr_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          PC_WIDTH  = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    instr_fetch_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    wptr_reg, rptr_reg;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [31:0]         instr_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

    logic                push_ready, pop_valid, push_fire, pop_fire;
    logic [31:0]         head_instr;
    logic [PC_WIDTH-1:0] head_pc;

    // Ready looks only at the registered count: no write-through when full.
    assign push_ready = (count_reg != FULL_COUNT);
    assign pop_valid  = (count_reg != '0) && !bus.flush_in;
    assign push_fire  = bus.push_valid_in && push_ready && !bus.flush_in;
    assign pop_fire   = pop_valid && bus.pop_ready_in;

    // Storage: one register pair per entry, deliberately not reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [31:0]         instr_reg;
        logic [PC_WIDTH-1:0] pc_reg;

        always_ff @(posedge clk_in) begin
            if (push_fire && (wptr_reg == PTR_W'(gi))) begin
                instr_reg <= bus.instr_in;
                pc_reg    <= bus.pc_in;
            end
        end

        assign instr_mem[gi] = instr_reg;
        assign pc_mem[gi]    = pc_reg;
    end

    always_comb begin
        count_next = count_reg;
        case ({push_fire, pop_fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else if (bus.flush_in) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_fire) wptr_reg <= wptr_reg + 1'b1;
            if (pop_fire)  rptr_reg <= rptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Head view: NOP and zero PC whenever empty or flushing.
    assign head_instr = pop_valid ? instr_mem[rptr_reg] : NOP_INSTR;
    assign head_pc    = pop_valid ? pc_mem[rptr_reg]    : '0;

    assign bus.push_ready_out = push_ready;
    assign bus.pop_valid_out  = pop_valid;
    assign bus.count_out      = count_reg;
    assign bus.pc_out         = head_pc;
    assign bus.opcode_out     = head_instr[6:0];
    assign bus.rd_addr_out    = head_instr[11:7];
    assign bus.funct3_out     = head_instr[14:12];
    assign bus.rs1_addr_out   = head_instr[19:15];
    assign bus.rs2_addr_out   = head_instr[24:20];
    assign bus.funct7_out     = head_instr[31:25];
    assign bus.csr_addr_out   = head_instr[31:20];
    assign bus.instr_31_7_out = head_instr[31:7];
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised instruction buffer between the fetch unit and the decode stage.
- Holds up to DEPTH fetched instruction/PC pairs, using valid/ready handshakes on both sides.
- Presents the head entry to decode already split into fields.
- Substitutes the canonical NOP (addi x0,x0,0 = 32'h0000_0013) whenever the queue is empty or being flushed, so decode never sees a stale or garbage instruction.

Parameters:
- DEPTH, 4: number of entries. Must be a power of two, >= 2.
- PC_WIDTH, 32: width of the stored program counter.
- NOP_INSTR, 32'h0000_0013: instruction word substituted on empty/flush.

Ports:
- clk_in  input  1  rising-edge clock
- rst_n_in  input  1  reset, asynchronous assert, active-low
- flush_in  input  1  discard all entries (branch/trap redirect)
- push_valid_in  input  1  fetch presents an instruction
- push_ready_out  output  1  queue can accept; equals (count_out < DEPTH)
- instr_in  input  32  fetched instruction word
- pc_in  input  PC_WIDTH  PC of instr_in
- pop_ready_in  input  1  decode consumes the head this cycle
- pop_valid_out  output  1  head entry is valid
- pc_out  output  PC_WIDTH  PC of head; 0 when not valid
- opcode_out  output  7  head[6:0]
- funct3_out  output  3  head[14:12]
- funct7_out  output  7  head[31:25]
- rs1_addr_out  output  5  head[19:15]
- rs2_addr_out  output  5  head[24:20]
- rd_addr_out  output  5  head[11:7]
- csr_addr_out  output  12  head[31:20]
- instr_31_7_out  output  25  head[31:7], full 25 bits
- count_out  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - write pointer, read pointer and count go to 0.
  - pop_valid_out=0, push_ready_out=1, count_out=0, pc_out=0.
  - All field outputs carry NOP_INSTR fields: opcode 7'h13, every other field 0.
  - Storage array is not reset.
- Push: when push_valid_in && push_ready_out && !flush_in at a rising edge, store {instr_in, pc_in} at wptr; wptr increments modulo DEPTH.
- Pop: when pop_valid_out && pop_ready_in && !flush_in at a rising edge, rptr increments modulo DEPTH.
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged. This is allowed whenever 0 < count < DEPTH.
- Full: push_ready_out=0 at count==DEPTH. There is no write-through when full, even if a pop occurs in the same cycle; push_ready_out depends only on registered count.
- Empty: pop_valid_out=0. A push into an empty queue is visible at the head the cycle after the write edge (1-cycle latency, no bypass).
- Head presentation:
  - Purely combinational from storage[rptr], with pop_valid_out = (count != 0) && !flush_in.
  - When pop_valid_out=0, field outputs come from NOP_INSTR and pc_out=0.
- Flush:
  - flush_in high forces NOP fields and pop_valid_out=0 in the same cycle, combinationally.
  - At the next edge wptr, rptr and count clear to 0. Any simultaneous push or pop is ignored (flush wins).
  - push_ready_out is not gated by flush_in.
- Flush held multiple cycles: the queue stays empty; pushes are dropped every cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is one bit wider so that full and empty are distinguishable.
- pop_ready_in while pop_valid_out=0 has no effect. push_valid_in with push_ready_out=0 has no effect; fetch must hold data.
- Reset asserted mid-operation clears state immediately, regardless of clock.

Test Plan:
1. Reset release, no traffic -> count_out=0, pop_valid_out=0, opcode_out=7'h13, rd_addr_out=0, pc_out=0, push_ready_out=1.
2. Push 32'h00A00093 (addi x1,x0,10) @ pc 0x100, pop_ready_in=0:
   - next cycle pop_valid_out=1, opcode 7'h13, rd 1, rs1 0, csr_addr_out 12'h00A, pc_out 0x100, count 1.
3. Push 4 distinct words with pop_ready_in=0 (DEPTH=4):
   - count reaches 4, push_ready_out=0, a fifth push is ignored.
   - Popping 4 returns the words in order; afterwards pop_valid_out=0 and NOP fields.
4. Continuous push+pop streaming 10 words at count=2:
   - count stays 2, pointers wrap twice, output order is preserved, no loss or duplication.
5. Fill with 3 entries, assert flush_in for 1 cycle with push_valid_in=1:
   - same cycle pop_valid_out=0 and opcode 7'h13; next cycle count 0 and the pushed word is absent.
6. Assert rst_n_in low asynchronously between edges while count=3:
   - count_out=0 and pop_valid_out=0 immediately, before the next clock edge.
